// File: rtl/coolgirl_cpu_bus_master_pkg.sv
// Shared timing defaults, phase-FSM encoding and request payload for the
// CoolGirl CPU-side bus initiator.
package coolgirl_cpu_bus_defs;

    localparam int unsigned DEF_M2_LOW_CLKS  = 5;
    localparam int unsigned DEF_M2_HIGH_CLKS = 7;
    localparam int unsigned DEF_ADDR_DLY     = 1;
    localparam int unsigned DEF_WDATA_DLY    = 2;
    localparam logic [15:0] DEF_IDLE_ADDR    = 16'h0000;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_LOW     = 2'd1,
        ST_HIGH    = 2'd2
    } cyc_state_t;

    typedef struct packed {
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } bus_req_t;

endpackage

// File: rtl/coolgirl_cpu_bus_master_timer.sv
// M2 phase generator: STOPPED/LOW/HIGH sequencer with a per-cycle clock counter.
// The *_c strobes look one edge ahead, so registers loaded on them change
// exactly when the counter reaches the named position.
module coolgirl_cpu_cycle_timer
    import coolgirl_cpu_bus_defs::*;
#(
    parameter int unsigned M2_LOW_CLKS  = DEF_M2_LOW_CLKS,
    parameter int unsigned M2_HIGH_CLKS = DEF_M2_HIGH_CLKS,
    parameter int unsigned ADDR_DLY     = DEF_ADDR_DLY,
    parameter int unsigned WDATA_DLY    = DEF_WDATA_DLY
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic m2,
    output logic m2_nxt_c,
    output logic start_c,
    output logic addr_c,
    output logic wdata_c,
    output logic sample_c
);

    localparam int unsigned P  = M2_LOW_CLKS + M2_HIGH_CLKS;
    localparam int unsigned CW = $clog2(P);

    localparam logic [CW-1:0] CNT_LAST     = CW'(P - 1);
    localparam logic [CW-1:0] CNT_LOW_LAST = CW'(M2_LOW_CLKS - 1);
    localparam logic [CW-1:0] CNT_ADDR     = CW'(ADDR_DLY);
    localparam logic [CW-1:0] CNT_WDATA    = CW'(M2_LOW_CLKS + WDATA_DLY);

    cyc_state_t    state;
    cyc_state_t    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    // Next phase; enable is only looked at between bus cycles.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_STOPPED: begin
                cnt_nxt = '0;
                if (enable) begin
                    state_nxt = ST_LOW;
                end
            end
            ST_LOW: begin
                cnt_nxt = cnt + CW'(1);
                if (cnt == CNT_LOW_LAST) begin
                    state_nxt = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = enable ? ST_LOW : ST_STOPPED;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = ST_STOPPED;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign m2_nxt_c = (state_nxt == ST_HIGH);
    assign start_c  = (state_nxt == ST_LOW) && (cnt_nxt == '0);
    assign addr_c   = (state_nxt == ST_LOW) && (cnt_nxt == CNT_ADDR);
    assign wdata_c  = (state_nxt == ST_HIGH) && (cnt_nxt == CNT_WDATA);
    assign sample_c = (state == ST_HIGH) && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_STOPPED;
            cnt   <= '0;
            m2    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            m2    <= m2_nxt_c;
        end
    end

endmodule

// File: rtl/coolgirl_cpu_bus_master.sv
// Famicom CPU-side bus initiator toward a CoolGirl cartridge: one-entry request
// buffer, active bus-cycle slot and registered cartridge pins.
module coolgirl_cpu_bus_master
    import coolgirl_cpu_bus_defs::*;
#(
    parameter int unsigned M2_LOW_CLKS  = DEF_M2_LOW_CLKS,
    parameter int unsigned M2_HIGH_CLKS = DEF_M2_HIGH_CLKS,
    parameter int unsigned ADDR_DLY     = DEF_ADDR_DLY,
    parameter int unsigned WDATA_DLY    = DEF_WDATA_DLY,
    parameter logic [15:0] IDLE_ADDR    = DEF_IDLE_ADDR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        busy,
    output logic        m2,
    output logic        romsel,
    output logic        cpu_rw,
    output logic [14:0] cpu_addr,
    output logic [7:0]  cpu_data_out,
    output logic        cpu_data_oe,
    input  logic [7:0]  cpu_data_in
);

    logic m2_nxt_c;
    logic start_c;
    logic addr_c;
    logic wdata_c;
    logic sample_c;

    coolgirl_cpu_cycle_timer #(
        .M2_LOW_CLKS  (M2_LOW_CLKS),
        .M2_HIGH_CLKS (M2_HIGH_CLKS),
        .ADDR_DLY     (ADDR_DLY),
        .WDATA_DLY    (WDATA_DLY)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .m2       (m2),
        .m2_nxt_c (m2_nxt_c),
        .start_c  (start_c),
        .addr_c   (addr_c),
        .wdata_c  (wdata_c),
        .sample_c (sample_c)
    );

    bus_req_t buf_q;
    bus_req_t act_q;
    bus_req_t act_nxt;
    logic     buf_full;
    logic     buf_full_nxt;
    logic     act_valid;
    logic     act_valid_nxt;
    logic     accept;
    logic     a15;
    logic     a15_nxt;
    logic     rd_done;

    // Slot bookkeeping; act_nxt lets the pins see a request loaded on the same edge.
    always_comb begin
        accept        = req_valid && req_ready;
        act_nxt       = act_q;
        act_valid_nxt = act_valid;
        buf_full_nxt  = buf_full;
        if (sample_c) begin
            act_valid_nxt = 1'b0;
        end
        if (start_c) begin
            act_nxt       = buf_q;
            act_valid_nxt = buf_full;
            buf_full_nxt  = 1'b0;
        end
        if (accept) begin
            buf_full_nxt = 1'b1;
        end
        a15_nxt = a15;
        if (addr_c) begin
            a15_nxt = act_valid_nxt ? act_nxt.addr[15] : IDLE_ADDR[15];
        end
        rd_done = sample_c && act_valid && act_q.rw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q     <= '0;
            act_q     <= '0;
            buf_full  <= 1'b0;
            act_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            if (accept) begin
                buf_q <= '{rw: req_rw, addr: req_addr, wdata: req_wdata};
            end
            act_q     <= act_nxt;
            buf_full  <= buf_full_nxt;
            act_valid <= act_valid_nxt;
            req_ready <= ~buf_full_nxt;
            busy      <= buf_full_nxt | act_valid_nxt;
        end
    end

    // Cartridge pins; write data is held past M2 fall until the next address update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a15          <= IDLE_ADDR[15];
            cpu_addr     <= IDLE_ADDR[14:0];
            cpu_rw       <= 1'b1;
            romsel       <= 1'b1;
            cpu_data_out <= 8'h00;
            cpu_data_oe  <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 8'h00;
        end else begin
            a15    <= a15_nxt;
            romsel <= ~(m2_nxt_c & a15_nxt);
            if (addr_c) begin
                cpu_addr    <= act_valid_nxt ? act_nxt.addr[14:0] : IDLE_ADDR[14:0];
                cpu_rw      <= act_valid_nxt ? act_nxt.rw : 1'b1;
                cpu_data_oe <= 1'b0;
            end else if (wdata_c && act_valid && !act_q.rw) begin
                cpu_data_out <= act_q.wdata;
                cpu_data_oe  <= 1'b1;
            end
            rsp_valid <= rd_done;
            if (rd_done) begin
                rsp_rdata <= cpu_data_in;
            end
        end
    end

endmodule

// File: tb/tb_coolgirl_cpu_bus_master.sv
// Bench for coolgirl_cpu_bus_master: directed scenarios plus a random phase,
// checked every clock against a cycle-position reference model.
module tb_coolgirl_cpu_bus_master;

    localparam int L  = 5;
    localparam int H  = 7;
    localparam int P  = L + H;
    localparam int AD = 1;
    localparam int WD = 2;
    localparam logic [15:0] IDLE = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_rw = 1'b1;
    logic [15:0] req_addr = 16'h0000;
    logic [7:0]  req_wdata = 8'h00;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        busy;
    logic        m2;
    logic        romsel;
    logic        cpu_rw;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_data_oe;
    logic [7:0]  cpu_data_in = 8'h00;

    always #5 clk = ~clk;

    coolgirl_cpu_bus_master dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rw       (req_rw),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .busy         (busy),
        .m2           (m2),
        .romsel       (romsel),
        .cpu_rw       (cpu_rw),
        .cpu_addr     (cpu_addr),
        .cpu_data_out (cpu_data_out),
        .cpu_data_oe  (cpu_data_oe),
        .cpu_data_in  (cpu_data_in)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: position inside the current bus cycle plus request slots.
    bit          running;
    int          pos;
    bit          b_full;
    logic        b_rw;
    logic [15:0] b_addr;
    logic [7:0]  b_wd;
    bit          c_valid;
    logic        c_rw;
    logic [15:0] c_addr;
    logic [7:0]  c_wd;
    logic        e_m2, e_romsel, e_rw, e_oe, e_rsp, e_ready, e_busy;
    logic [15:0] e_addr;
    logic [7:0]  e_dout, e_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [14:0] ea;
        ea = e_addr[14:0];
        chk("m2", 32'(m2), 32'(e_m2));
        chk("romsel", 32'(romsel), 32'(e_romsel));
        chk("cpu_rw", 32'(cpu_rw), 32'(e_rw));
        chk("cpu_addr", 32'(cpu_addr), 32'(ea));
        chk("cpu_data_oe", 32'(cpu_data_oe), 32'(e_oe));
        chk("cpu_data_out", 32'(cpu_data_out), 32'(e_dout));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(e_rdata));
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("busy", 32'(busy), 32'(e_busy));
    endtask

    task automatic model_reset();
        running = 0; pos = 0; b_full = 0; c_valid = 0;
        b_rw = 1; b_addr = 0; b_wd = 0; c_rw = 1; c_addr = 0; c_wd = 0;
        e_m2 = 0; e_romsel = 1; e_rw = 1; e_addr = IDLE; e_oe = 0; e_dout = 0;
        e_rsp = 0; e_rdata = 0; e_ready = 1; e_busy = 0;
    endtask

    // Advance the model over one clock using the inputs as currently driven,
    // then let the DUT take the same edge and compare.
    task automatic step();
        bit accept, leaving, starting;
        accept   = req_valid && e_ready;
        leaving  = running && (pos == P - 1);
        starting = 0;
        if (!running) begin
            if (enable) begin running = 1; pos = 0; starting = 1; end
        end else if (pos == P - 1) begin
            pos = 0;
            if (enable) starting = 1;
            else running = 0;
        end else begin
            pos++;
        end
        e_rsp = leaving && c_valid && c_rw;
        if (e_rsp) e_rdata = cpu_data_in;
        if (leaving) c_valid = 0;
        if (starting) begin
            c_valid = b_full; c_rw = b_rw; c_addr = b_addr; c_wd = b_wd; b_full = 0;
        end
        if (accept) begin
            b_full = 1; b_rw = req_rw; b_addr = req_addr; b_wd = req_wdata;
        end
        if (running && pos == AD) begin
            e_addr = c_valid ? c_addr : IDLE;
            e_rw   = c_valid ? c_rw : 1'b1;
            e_oe   = 0;
        end
        if (running && pos == L + WD && c_valid && !c_rw) begin
            e_oe = 1; e_dout = c_wd;
        end
        e_m2     = running && (pos >= L);
        e_romsel = !(e_m2 && e_addr[15]);
        e_ready  = !b_full;
        e_busy   = b_full || c_valid;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic run(input int n, input bit rnd_din);
        for (int i = 0; i < n; i++) begin
            if (rnd_din) cpu_data_in = 8'($urandom);
            step();
        end
    endtask

    // Present one request and hold it until the model says it was taken.
    task automatic send(input logic rw, input logic [15:0] a, input logic [7:0] d);
        bit done;
        done = 0;
        req_valid = 1; req_rw = rw; req_addr = a; req_wdata = d;
        for (int i = 0; i < 4 * P && !done; i++) begin
            done = e_ready;
            step();
        end
        req_valid = 0;
        chk("send_accepted", 32'(done), 32'd1);
    endtask

    initial begin
        int m2_high, rsp_cnt;
        bit seen_low, found;

        // 1: reset values, then free-running idle cycles
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1; enable = 1;
        m2_high = 0;
        for (int i = 0; i < 2 * P; i++) begin
            cpu_data_in = 8'($urandom);
            step();
            if (m2 === 1'b1) m2_high++;
        end
        chk("idle_m2_high_clks", 32'(m2_high), 32'(2 * H));

        // 2: write $8000 = 0x5A
        send(1'b0, 16'h8000, 8'h5A);
        run(2 * P, 1);

        // 3: read $6000 with the cartridge returning 0xA5
        cpu_data_in = 8'hA5;
        send(1'b1, 16'h6000, 8'h00);
        rsp_cnt = 0;
        for (int i = 0; i < 2 * P + 2; i++) begin
            step();
            if (rsp_valid === 1'b1) rsp_cnt++;
        end
        chk("read_rsp_count", 32'(rsp_cnt), 32'd1);
        chk("read_rdata", 32'(rsp_rdata), 32'h0A5);

        // 4: three back-to-back requests
        seen_low = 0;
        send(1'b0, 16'h9000, 8'h11);
        if (req_ready === 1'b0) seen_low = 1;
        send(1'b1, 16'hC000, 8'h00);
        if (req_ready === 1'b0) seen_low = 1;
        send(1'b0, 16'h7123, 8'h33);
        if (req_ready === 1'b0) seen_low = 1;
        run(4 * P, 1);
        chk("b2b_ready_low_seen", 32'(seen_low), 32'd1);

        // 5: stop at cnt 3 with a request waiting in the buffer, then resume
        found = 0;
        for (int i = 0; i < 2 * P && !found; i++) begin
            if (running && pos == 3) found = 1;
            else step();
        end
        chk("reach_cnt3", 32'(found), 32'd1);
        enable = 0;
        send(1'b0, 16'hA000, 8'h77);
        run(3 * P, 1);
        chk("stopped_m2", 32'(m2), 32'd0);
        chk("stopped_busy", 32'(busy), 32'd1);
        enable = 1;
        run(3 * P, 1);

        // 6: reset in the middle of a write
        send(1'b0, 16'h8123, 8'hC3);
        found = 0;
        for (int i = 0; i < 3 * P && !found; i++) begin
            if (running && pos == 9 && c_valid && !c_rw) found = 1;
            else step();
        end
        chk("reach_write_cnt9", 32'(found), 32'd1);
        chk("pre_reset_oe", 32'(cpu_data_oe), 32'd1);
        rst_n = 0;
        #1;
        chk("rst_m2", 32'(m2), 32'd0);
        chk("rst_oe", 32'(cpu_data_oe), 32'd0);
        chk("rst_rw", 32'(cpu_rw), 32'd1);
        chk("rst_romsel", 32'(romsel), 32'd1);
        chk("rst_rsp", 32'(rsp_valid), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        check_all();
        run(3 * P, 1);

        // 7: random traffic with occasional enable toggles
        for (int i = 0; i < 500; i++) begin
            bit acc;
            cpu_data_in = 8'($urandom);
            if ($urandom_range(0, 24) == 0) enable = ~enable;
            if (!req_valid && $urandom_range(0, 2) == 0) begin
                req_valid = 1;
                req_rw    = 1'($urandom);
                req_addr  = 16'($urandom);
                req_wdata = 8'($urandom);
            end
            acc = req_valid && e_ready;
            step();
            if (acc) req_valid = 0;
        end
        enable = 1;
        run(3 * P, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
